// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, waits for a stable synchronized lock, then releases the
// downstream reset bank in order; re-runs the whole sequence on loss or request.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT       = 65536,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int NUM_STAGES         = 3,
   parameter int STAGE_GAP          = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pll_locked,
   input  logic                  relock_req,
   output logic                  pll_rst,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  ready,
   output logic [7:0]            loss_count,
   output logic [7:0]            timeout_count
);

   localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B   = (LOCK_STABLE_CYCLES > STAGE_GAP*NUM_STAGES) ?
                            LOCK_STABLE_CYCLES : STAGE_GAP*NUM_STAGES;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(STAGE_GAP*(NUM_STAGES - 1));

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             sync0;
   logic             locked_s;
   logic             lock_lost;
   logic             relock;
   logic             restart;

   // Loss outranks a simultaneous relock so that it is still counted.
   always_comb begin
      lock_lost = ((state == S_RELEASE) || (state == S_RUN)) && !locked_s;
      relock    = relock_req && (state != S_PLL_RST);
      restart   = lock_lost || relock;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_PLL_RST;
         cnt           <= '0;
         sync0         <= 1'b0;
         locked_s      <= 1'b0;
         pll_rst       <= 1'b1;
         rst_out       <= '1;
         ready         <= 1'b0;
         loss_count    <= 8'd0;
         timeout_count <= 8'd0;
      end else begin
         sync0    <= pll_locked;
         locked_s <= sync0;
         if (restart) begin
            state   <= S_PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
            rst_out <= '1;
            ready   <= 1'b0;
            if (lock_lost && (loss_count != 8'hFF))
               loss_count <= loss_count + 8'd1;
         end else begin
            case (state)
               S_PLL_RST: begin
                  if (cnt == RST_LAST) begin
                     state   <= S_WAIT_LOCK;
                     cnt     <= '0;
                     pll_rst <= 1'b0;
                  end else
                     cnt <= cnt + 1'b1;
               end
               // The sample that leaves WAIT_LOCK is the first of the stable run.
               S_WAIT_LOCK: begin
                  if (locked_s) begin
                     if (LOCK_STABLE_CYCLES == 1) begin
                        state      <= S_RELEASE;
                        cnt        <= '0;
                        rst_out[0] <= 1'b0;
                     end else begin
                        state <= S_STABLE;
                        cnt   <= CNT_W'(1);
                     end
                  end else if (cnt == TIMEOUT_LAST) begin
                     state   <= S_PLL_RST;
                     cnt     <= '0;
                     pll_rst <= 1'b1;
                     if (timeout_count != 8'hFF)
                        timeout_count <= timeout_count + 8'd1;
                  end else
                     cnt <= cnt + 1'b1;
               end
               S_STABLE: begin
                  if (!locked_s) begin
                     state <= S_WAIT_LOCK;
                     cnt   <= '0;
                  end else if (cnt == STABLE_LAST) begin
                     state      <= S_RELEASE;
                     cnt        <= '0;
                     rst_out[0] <= 1'b0;
                  end else
                     cnt <= cnt + 1'b1;
               end
               S_RELEASE: begin
                  if (cnt == RELEASE_LAST) begin
                     state <= S_RUN;
                     ready <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                     for (int i = 1; i < NUM_STAGES; i++)
                        if (cnt == CNT_W'(STAGE_GAP*i - 1))
                           rst_out[i] <= 1'b0;
                  end
               end
               S_RUN: begin
               end
               default: begin
                  state   <= S_PLL_RST;
                  cnt     <= '0;
                  pll_rst <= 1'b1;
                  rst_out <= '1;
                  ready   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: cold start, lock loss, relock, glitch,
// reset mid-release and timeout saturation, with hand-computed cycle counts.
module tb_pll_reset_sequencer;

   localparam int N     = 3;
   localparam int BOUND = 200;

   localparam int SEL_REL0    = 0;
   localparam int SEL_REL1    = 1;
   localparam int SEL_REL2    = 2;
   localparam int SEL_READY   = 3;
   localparam int SEL_PRST_HI = 4;
   localparam int SEL_PRST_LO = 5;

   logic         clk;
   logic         rst_n;
   logic         pll_locked;
   logic         relock_req;
   logic         pll_rst;
   logic [N-1:0] rst_out;
   logic         ready;
   logic [7:0]   loss_count;
   logic [7:0]   timeout_count;

   int total = 0;
   int bad   = 0;
   int n;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32), .LOCK_STABLE_CYCLES(8),
      .NUM_STAGES(N), .STAGE_GAP(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .relock_req(relock_req),
      .pll_rst(pll_rst), .rst_out(rst_out), .ready(ready),
      .loss_count(loss_count), .timeout_count(timeout_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic logic cond(input int sel);
      case (sel)
         SEL_REL0:    return rst_out[0] == 1'b0;
         SEL_REL1:    return rst_out[1] == 1'b0;
         SEL_REL2:    return rst_out[2] == 1'b0;
         SEL_READY:   return ready == 1'b1;
         SEL_PRST_HI: return pll_rst == 1'b1;
         SEL_PRST_LO: return pll_rst == 1'b0;
         default:     return 1'b0;
      endcase
   endfunction

   // Edges elapsed from now until the selected condition holds.
   task automatic wait_until(input int sel, output int cnt);
      cnt = 0;
      while (!cond(sel) && cnt < BOUND) begin
         step(1);
         cnt++;
      end
      total++;
      assert (cond(sel)) else begin
         bad++;
         $error("FAIL wait_sel%0d observed=expired expected=event within %0d cycles", sel, BOUND);
      end
   endtask

   // Samples with pll_rst high, counting the current one.
   task automatic pulse_width(output int cnt);
      cnt = 0;
      while (pll_rst && cnt < BOUND) begin
         cnt++;
         step(1);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pll_rst"}, pll_rst, 1);
      chk({tag, "_rst_out"}, rst_out, 3'b111);
      chk({tag, "_ready"}, ready, 0);
      chk({tag, "_loss"}, loss_count, 0);
      chk({tag, "_tmo"}, timeout_count, 0);
   endtask

   initial begin
      rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
      step(5);
      check_reset_vals("reset");

      // Cold start
      rst_n = 1'b1;
      pulse_width(n);             chk("cold_prst_width", n, 4);
      step(2);
      pll_locked = 1'b1;
      wait_until(SEL_REL0, n);    chk("cold_rel0_lat", n, 10);
      chk("cold_rst_out_a", rst_out, 3'b110);
      wait_until(SEL_REL1, n);    chk("cold_rel1_gap", n, 4);
      chk("cold_rst_out_b", rst_out, 3'b100);
      wait_until(SEL_REL2, n);    chk("cold_rel2_gap", n, 4);
      chk("cold_ready_early", ready, 0);
      wait_until(SEL_READY, n);   chk("cold_ready_lat", n, 1);
      chk("cold_run_rst_out", rst_out, 3'b000);
      chk("cold_run_pll_rst", pll_rst, 0);
      chk("cold_loss", loss_count, 0);
      chk("cold_tmo", timeout_count, 0);

      // Lock loss in RUN, three sampled-low cycles
      pll_locked = 1'b0;
      step(2);
      chk("loss_hold_rst_out", rst_out, 3'b000);
      step(1);
      chk("loss_rst_out", rst_out, 3'b111);
      chk("loss_ready", ready, 0);
      chk("loss_pll_rst", pll_rst, 1);
      chk("loss_count", loss_count, 1);
      pll_locked = 1'b1;
      pulse_width(n);             chk("loss_prst_width", n, 4);
      wait_until(SEL_READY, n);   chk("loss_ready_again", n, 17);
      chk("loss_run_rst_out", rst_out, 3'b000);

      // relock_req in RUN
      relock_req = 1'b1; step(1); relock_req = 1'b0;
      chk("relock_pll_rst", pll_rst, 1);
      chk("relock_rst_out", rst_out, 3'b111);
      chk("relock_ready", ready, 0);
      chk("relock_loss", loss_count, 1);
      chk("relock_tmo", timeout_count, 0);

      // relock_req during PLL_RST must not stretch the pulse
      n = 1; step(1);
      relock_req = 1'b1; n++; step(1); relock_req = 1'b0;
      while (pll_rst && n < BOUND) begin n++; step(1); end
      chk("relock_in_rst_width", n, 4);
      wait_until(SEL_READY, n);   chk("relock_ready_again", n, 17);
      chk("relock_loss_after", loss_count, 1);

      // rst_n during RELEASE
      relock_req = 1'b1; step(1); relock_req = 1'b0;
      wait_until(SEL_REL0, n);    chk("mid_rel_rel0_lat", n, 12);
      rst_n = 1'b0; step(1); rst_n = 1'b1;
      check_reset_vals("mid_rel_reset");
      pulse_width(n);             chk("mid_rel_prst_width", n, 4);
      wait_until(SEL_READY, n);   chk("mid_rel_ready", n, 17);

      // Lock loss after stage 0 released, before stage 1
      relock_req = 1'b1; step(1); relock_req = 1'b0;
      wait_until(SEL_REL0, n);    chk("rel_loss_rel0_lat", n, 12);
      pll_locked = 1'b0;
      step(2);
      chk("rel_loss_before", rst_out, 3'b110);
      step(1);
      chk("rel_loss_rst_out", rst_out, 3'b111);
      chk("rel_loss_pll_rst", pll_rst, 1);
      chk("rel_loss_count", loss_count, 1);
      pll_locked = 1'b1;
      wait_until(SEL_READY, n);   chk("rel_loss_ready", n, 21);

      // Glitch during STABLE restarts the stable count
      pll_locked = 1'b0;
      relock_req = 1'b1; step(1); relock_req = 1'b0;
      wait_until(SEL_PRST_LO, n); chk("glitch_prst_width", n, 4);
      pll_locked = 1'b1; step(5);
      pll_locked = 1'b0; step(1);
      pll_locked = 1'b1;
      wait_until(SEL_REL0, n);    chk("glitch_rel0_lat", n, 10);
      wait_until(SEL_READY, n);   chk("glitch_ready", n, 9);
      chk("glitch_loss", loss_count, 1);
      chk("glitch_tmo", timeout_count, 0);

      // Lock timeout and saturation
      pll_locked = 1'b0;
      relock_req = 1'b1; step(1); relock_req = 1'b0;
      wait_until(SEL_PRST_LO, n); chk("tmo_first_width", n, 4);
      wait_until(SEL_PRST_HI, n); chk("tmo_wait_1", n, 32);
      chk("tmo_count_1", timeout_count, 1);
      pulse_width(n);             chk("tmo_width", n, 4);
      wait_until(SEL_PRST_HI, n); chk("tmo_wait_2", n, 32);
      chk("tmo_count_2", timeout_count, 2);
      chk("tmo_rst_out", rst_out, 3'b111);
      chk("tmo_ready", ready, 0);
      for (int k = 3; k <= 255; k++) begin
         wait_until(SEL_PRST_LO, n);
         wait_until(SEL_PRST_HI, n);
      end
      chk("tmo_count_255", timeout_count, 255);
      wait_until(SEL_PRST_LO, n);
      wait_until(SEL_PRST_HI, n);
      chk("tmo_saturated", timeout_count, 255);
      chk("tmo_loss", loss_count, 1);

      rst_n = 1'b0; step(1);
      check_reset_vals("final_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
